// File: rtl/cla_pkg.sv
// Shared constants and types for the pipelined carry-lookahead adder.
package cla_pkg;

   localparam int CLA_WIDTH  = 64;
   localparam int CLA_STAGES = 4;

   typedef struct packed {
      logic g;
      logic p;
   } gp_t;

   function automatic gp_t gp_of(input logic a, input logic b);
      gp_t r;
      r.g = a & b;
      r.p = a ^ b;
      return r;
   endfunction

endpackage

// File: rtl/cla_slice.sv
// One combinational carry-lookahead slice: every carry is a flat sum of
// generate terms gated by the propagates above them, not a ripple chain.
module cla_slice
   import cla_pkg::*;
#(
   parameter int W = 16
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         ci,
   output logic [W-1:0] s,
   output logic         co
);

   gp_t  [W-1:0] gp;
   logic [W:0]   c;

   always_comb begin
      for (int i = 0; i < W; i++) begin
         gp[i] = gp_of(a[i], b[i]);
      end
   end

   always_comb begin
      logic acc;
      logic term;
      acc  = 1'b0;
      term = 1'b0;
      c    = '0;
      c[0] = ci;
      for (int i = 0; i < W; i++) begin
         acc = ci;
         for (int j = 0; j <= i; j++) begin
            acc = acc & gp[j].p;
         end
         for (int j = 0; j <= i; j++) begin
            term = gp[j].g;
            for (int m = j + 1; m <= i; m++) begin
               term = term & gp[m].p;
            end
            acc = acc | term;
         end
         c[i+1] = acc;
      end
   end

   always_comb begin
      for (int i = 0; i < W; i++) begin
         s[i] = gp[i].p ^ c[i];
      end
   end

   assign co = c[W];

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined adder {cout,sum} = A + B + cin, one WIDTH/STAGES-bit CLA slice per stage.
// Define CLA_PIPE_OVF_EN to add the registered signed-overflow output ovf.
module cla_pipe_adder
   import cla_pkg::*;
#(
   parameter int WIDTH  = CLA_WIDTH,
   parameter int STAGES = CLA_STAGES
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             cin,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             out_valid,
`ifdef CLA_PIPE_OVF_EN
   output logic             ovf,
`endif
   input  logic             out_ready
);

   localparam int SW = WIDTH / STAGES;

   logic en;

   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   // Stage k holds the finished low slices in acc_q and only the still
   // unprocessed upper operand bits in g_op, so nothing is stored twice.
   for (genvar k = 0; k < STAGES; k++) begin : g_stg
      localparam int LO   = k * SW;
      localparam int DONE = LO + SW;
      localparam int REM  = WIDTH - DONE;

      logic [WIDTH-LO-1:0] opa_in;
      logic [WIDTH-LO-1:0] opb_in;
      logic [SW-1:0]       s_sl;
      logic                ci;
      logic                co;
      logic                v_in;
      logic [DONE-1:0]     acc_new;
      logic [DONE-1:0]     acc_d;
      logic [DONE-1:0]     acc_q;
      logic                c_d;
      logic                c_q;
      logic                v_d;
      logic                v_q;

      if (k == 0) begin : g_src
         assign opa_in  = A;
         assign opb_in  = B;
         assign ci      = cin;
         assign v_in    = in_valid;
         assign acc_new = s_sl;
      end else begin : g_src
         assign opa_in  = g_stg[k-1].g_op.opa_q;
         assign opb_in  = g_stg[k-1].g_op.opb_q;
         assign ci      = g_stg[k-1].c_q;
         assign v_in    = g_stg[k-1].v_q;
         assign acc_new = {s_sl, g_stg[k-1].acc_q};
      end

      cla_slice #(.W(SW)) u_slice (
         .a  (opa_in[SW-1:0]),
         .b  (opb_in[SW-1:0]),
         .ci (ci),
         .s  (s_sl),
         .co (co)
      );

      always_comb begin
         acc_d = acc_q;
         c_d   = c_q;
         v_d   = v_q;
         if (en) begin
            acc_d = acc_new;
            c_d   = co;
            v_d   = v_in;
         end
      end

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            acc_q <= '0;
            c_q   <= 1'b0;
            v_q   <= 1'b0;
         end else begin
            acc_q <= acc_d;
            c_q   <= c_d;
            v_q   <= v_d;
         end
      end

      if (REM > 0) begin : g_op
         logic [REM-1:0] opa_d;
         logic [REM-1:0] opa_q;
         logic [REM-1:0] opb_d;
         logic [REM-1:0] opb_q;

         always_comb begin
            opa_d = opa_q;
            opb_d = opb_q;
            if (en) begin
               opa_d = opa_in[WIDTH-LO-1:SW];
               opb_d = opb_in[WIDTH-LO-1:SW];
            end
         end

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               opa_q <= '0;
               opb_q <= '0;
            end else begin
               opa_q <= opa_d;
               opb_q <= opb_d;
            end
         end
      end
   end

   assign sum       = g_stg[STAGES-1].acc_q;
   assign cout      = g_stg[STAGES-1].c_q;
   assign out_valid = g_stg[STAGES-1].v_q;

`ifdef CLA_PIPE_OVF_EN
   logic ovf_d;
   logic ovf_q;
   logic msb_a;
   logic msb_b;
   logic msb_s;

   // a^b^s at the MSB recovers the carry into it without exposing slice internals.
   assign msb_a = g_stg[STAGES-1].opa_in[SW-1];
   assign msb_b = g_stg[STAGES-1].opb_in[SW-1];
   assign msb_s = g_stg[STAGES-1].s_sl[SW-1];

   always_comb begin
      ovf_d = ovf_q;
      if (en) begin
         ovf_d = msb_a ^ msb_b ^ msb_s ^ g_stg[STAGES-1].co;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed self-checking bench for cla_pipe_adder (WIDTH=64, STAGES=4).
module tb_cla_pipe_adder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [63:0] A;
   logic [63:0] B;
   logic        cin;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] sum;
   logic        cout;
   logic        out_valid;
   logic        out_ready;
`ifdef CLA_PIPE_OVF_EN
   logic        ovf;
`endif

   int checks = 0;
   int errors = 0;

   cla_pipe_adder #(.WIDTH(64), .STAGES(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .A         (A),
      .B         (B),
      .cin       (cin),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sum       (sum),
      .cout      (cout),
      .out_valid (out_valid),
`ifdef CLA_PIPE_OVF_EN
      .ovf       (ovf),
`endif
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic c, input logic v);
      A        = a;
      B        = b;
      cin      = c;
      in_valid = v;
   endtask

   task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      chk(tag, {65'h0, obs}, {65'h0, exp});
   endtask

   // {out_valid, cout, sum}
   task automatic chk_out(input string tag, input logic [65:0] exp);
      chk(tag, {out_valid, cout, sum}, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      out_ready = 1'b1;
      drive(64'h0, 64'h0, 1'b0, 1'b0);
      tick;
      tick;
      chk_out("reset_state", {2'b00, 64'h0});
      rst_n = 1'b1;
      chk1("ready_after_rst", in_ready, 1'b1);

      // all-ones + 1: carry through every slice, exact 4-cycle latency
      drive(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b1);
      tick;
      drive(64'h0, 64'h0, 1'b0, 1'b0);
      tick;
      tick;
      chk1("latency_not_early", out_valid, 1'b0);
      tick;
      chk_out("max_plus_one", {2'b11, 64'h0});

      // back-to-back stream
      drive(64'h1, 64'h1, 1'b0, 1'b1);
      tick;
      drive(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b1);
      tick;
      drive(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b0, 1'b1);
      tick;
      drive(64'h0, 64'h0, 1'b0, 1'b0);
      tick;
      chk_out("b2b_1p1", {2'b10, 64'h2});
      tick;
      chk_out("b2b_ffff", {2'b10, 64'h0000_0000_0001_0000});
      tick;
      chk_out("b2b_aa55", {2'b10, 64'hFFFF_FFFF_FFFF_FFFF});
      tick;
      chk1("b2b_drained", out_valid, 1'b0);

      // cin rippling across three slices, then a bubble, then MSB carry-out
      drive(64'h0000_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b1);
      tick;
      drive(64'h0, 64'h0, 1'b0, 1'b0);
      tick;
      drive(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
      tick;
      drive(64'h0, 64'h0, 1'b0, 1'b0);
      tick;
      chk_out("cin_chain", {2'b10, 64'h0001_0000_0000_0000});
      tick;
      chk1("bubble", out_valid, 1'b0);
      tick;
      chk_out("msb_cout", {2'b11, 64'h0});
      tick;
      chk1("pre_stall_empty", out_valid, 1'b0);

      // fill the pipe with out_ready low, hold 5 cycles, then release
      out_ready = 1'b0;
      drive(64'h1, 64'h2, 1'b0, 1'b1);
      tick;
      drive(64'h10, 64'h20, 1'b0, 1'b1);
      tick;
      drive(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
      tick;
      drive(64'h0000_0001_0000_0000, 64'hFFFF_FFFF_0000_0000, 1'b0, 1'b1);
      tick;
      chk_out("stall_head", {2'b10, 64'h3});
      chk1("stall_in_ready", in_ready, 1'b0);
      drive(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         tick;
         chk_out("stall_hold", {2'b10, 64'h3});
         chk1("stall_hold_ready", in_ready, 1'b0);
      end
      out_ready = 1'b1;
      tick;
      drive(64'h0, 64'h0, 1'b0, 1'b0);
      chk_out("release_p1", {2'b10, 64'h30});
      tick;
      chk_out("release_p2", {2'b11, 64'hFFFF_FFFF_FFFF_FFFF});
      tick;
      chk_out("release_p3", {2'b11, 64'h0});
      tick;
      chk_out("release_p4", {2'b10, 64'h2345_6789_ABCD_F001});
      tick;
      chk1("release_drained", out_valid, 1'b0);

      // one-cycle reset with three results in flight
      drive(64'h5, 64'h6, 1'b0, 1'b1);
      tick;
      drive(64'h7, 64'h8, 1'b0, 1'b1);
      tick;
      drive(64'h9, 64'hA, 1'b0, 1'b1);
      tick;
      drive(64'h0, 64'h0, 1'b0, 1'b0);
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      chk_out("flush_state", {2'b00, 64'h0});
      chk1("flush_ready", in_ready, 1'b1);
      for (int i = 0; i < 6; i++) begin
         tick;
         chk1("flush_no_ghost", out_valid, 1'b0);
      end

      drive(64'h0, 64'h0, 1'b1, 1'b1);
      tick;
      drive(64'h0, 64'h0, 1'b0, 1'b0);
      tick;
      tick;
      tick;
      chk_out("recover_cin", {2'b10, 64'h1});

`ifdef CLA_PIPE_OVF_EN
      drive(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b1);
      tick;
      drive(64'hFFFF_FFFF_FFFF_FF00, 64'hFF, 1'b1, 1'b1);
      tick;
      drive(64'h0, 64'h0, 1'b0, 1'b0);
      tick;
      tick;
      chk_out("ovf_pos_sum", {2'b10, 64'h8000_0000_0000_0000});
      chk1("ovf_pos", ovf, 1'b1);
      tick;
      chk_out("ovf_neg_sum", {2'b11, 64'h0});
      chk1("ovf_neg", ovf, 1'b0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
